// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding selects with saturating
// forwarding-event counters for performance debug.
module forwarding_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EX_MEM_RegWrite,
  input  logic [REG_W-1:0] EX_MEM_RegisterRd,
  input  logic             MEM_WB_RegWrite,
  input  logic [REG_W-1:0] MEM_WB_RegisterRd,
  input  logic [REG_W-1:0] ID_EX_RegisterRs,
  input  logic [REG_W-1:0] ID_EX_RegisterRt,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [CNT_W-1:0] fwd_ex_count,
  output logic [CNT_W-1:0] fwd_mem_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_EX  = 2'b10;

  logic ex_live, mem_live;
  logic ex_a, mem_a, ex_b, mem_b;
  logic ex_hit, mem_hit;

  logic [CNT_W-1:0] fwd_ex_count_d, fwd_ex_count_q;
  logic [CNT_W-1:0] fwd_mem_count_d, fwd_mem_count_q;

  // r0 is hardwired zero, so a write to it never produces a value
  assign ex_live  = EX_MEM_RegWrite && (EX_MEM_RegisterRd != '0);
  assign mem_live = MEM_WB_RegWrite && (MEM_WB_RegisterRd != '0);

  assign ex_a  = ex_live  && (EX_MEM_RegisterRd == ID_EX_RegisterRs);
  assign mem_a = mem_live && (MEM_WB_RegisterRd == ID_EX_RegisterRs);
  assign ex_b  = ex_live  && (EX_MEM_RegisterRd == ID_EX_RegisterRt);
  assign mem_b = mem_live && (MEM_WB_RegisterRd == ID_EX_RegisterRt);

  always_comb begin
    ForwardA = SEL_RF;
    priority case (1'b1)
      ex_a:    ForwardA = SEL_EX;
      mem_a:   ForwardA = SEL_MEM;
      default: ForwardA = SEL_RF;
    endcase
  end

  always_comb begin
    ForwardB = SEL_RF;
    priority case (1'b1)
      ex_b:    ForwardB = SEL_EX;
      mem_b:   ForwardB = SEL_MEM;
      default: ForwardB = SEL_RF;
    endcase
  end

  assign ex_hit  = (ForwardA == SEL_EX)  || (ForwardB == SEL_EX);
  assign mem_hit = (ForwardA == SEL_MEM) || (ForwardB == SEL_MEM);

  always_comb begin
    fwd_ex_count_d  = fwd_ex_count_q;
    fwd_mem_count_d = fwd_mem_count_q;
    if (ex_hit && (fwd_ex_count_q != '1))
      fwd_ex_count_d = fwd_ex_count_q + 1'b1;
    if (mem_hit && (fwd_mem_count_q != '1))
      fwd_mem_count_d = fwd_mem_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_ex_count_q  <= '0;
      fwd_mem_count_q <= '0;
    end else begin
      fwd_ex_count_q  <= fwd_ex_count_d;
      fwd_mem_count_q <= fwd_mem_count_d;
    end
  end

  assign fwd_ex_count  = fwd_ex_count_q;
  assign fwd_mem_count = fwd_mem_count_q;

endmodule

// File: tb/tb_forwarding_unit.sv
// Bench for forwarding_unit: directed cases plus random
// traffic against a rule-level reference model.
module tb_forwarding_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_ex, wr_mem;
  logic [REG_W-1:0] rd_ex, rd_mem, rs, rt;
  logic [1:0]       fa, fb;
  logic [CNT_W-1:0] ex_cnt, mem_cnt;

  int checks = 0;
  int errors = 0;
  int m_ex   = 0;
  int m_mem  = 0;

  always #5 clk = ~clk;

  forwarding_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .EX_MEM_RegWrite   (wr_ex),
    .EX_MEM_RegisterRd (rd_ex),
    .MEM_WB_RegWrite   (wr_mem),
    .MEM_WB_RegisterRd (rd_mem),
    .ID_EX_RegisterRs  (rs),
    .ID_EX_RegisterRt  (rt),
    .ForwardA          (fa),
    .ForwardB          (fb),
    .fwd_ex_count      (ex_cnt),
    .fwd_mem_count     (mem_cnt)
  );

  // Most recent producer wins; r0 and non-writing stages never supply
  function automatic logic [1:0] ref_sel(input int src);
    if (wr_ex && rd_ex != 0 && int'(rd_ex) == src) return 2'b10;
    if (wr_mem && rd_mem != 0 && int'(rd_mem) == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(input logic r, input logic we, input int de,
                       input logic wm, input int dm,
                       input int s, input int t);
    @(negedge clk);
    rst = r; wr_ex = we; rd_ex = de[REG_W-1:0];
    wr_mem = wm; rd_mem = dm[REG_W-1:0];
    rs = s[REG_W-1:0]; rt = t[REG_W-1:0];
    #1;
  endtask

  task automatic tick();
    logic [1:0] ea, eb;
    ea = ref_sel(int'(rs));
    eb = ref_sel(int'(rt));
    @(posedge clk);
    #1;
    if (rst) begin
      m_ex = 0; m_mem = 0;
    end else begin
      if ((ea == 2'b10 || eb == 2'b10) && m_ex < CMAX) m_ex++;
      if ((ea == 2'b01 || eb == 2'b01) && m_mem < CMAX) m_mem++;
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (fa !== 2'b00 || fb !== 2'b00) begin
      errors++;
      $display("FAIL reset_sel: got A=%b B=%b want 00/00", fa, fb);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (ex_cnt !== 0 || mem_cnt !== 0) begin
      errors++;
      $display("FAIL reset_cnt: got ex=%0d mem=%0d want 0/0", ex_cnt, mem_cnt);
    end
  endtask

  task automatic test_ex_a();
    drive(0, 1, 5, 0, 0, 5, 0);
    checks++;
    if (fa !== 2'b10 || fb !== 2'b00) begin
      errors++;
      $display("FAIL ex_a: got A=%b B=%b want 10/00", fa, fb);
    end
    tick();
    checks++;
    if (ex_cnt !== 1 || mem_cnt !== 0) begin
      errors++;
      $display("FAIL ex_a_cnt: got ex=%0d mem=%0d want 1/0", ex_cnt, mem_cnt);
    end
  endtask

  task automatic test_ex_b();
    drive(0, 1, 5, 0, 0, 2, 5);
    checks++;
    if (fa !== 2'b00 || fb !== 2'b10) begin
      errors++;
      $display("FAIL ex_b: got A=%b B=%b want 00/10", fa, fb);
    end
    tick();
  endtask

  task automatic test_mem_b();
    drive(0, 0, 2, 1, 5, 2, 5);
    checks++;
    if (fa !== 2'b00 || fb !== 2'b01) begin
      errors++;
      $display("FAIL mem_b: got A=%b B=%b want 00/01", fa, fb);
    end
    tick();
    checks++;
    if (ex_cnt !== 2 || mem_cnt !== 1) begin
      errors++;
      $display("FAIL mem_b_cnt: got ex=%0d mem=%0d want 2/1", ex_cnt, mem_cnt);
    end
  endtask

  task automatic test_priority();
    drive(0, 1, 5, 1, 5, 5, 5);
    checks++;
    if (fa !== 2'b10 || fb !== 2'b10) begin
      errors++;
      $display("FAIL ex_priority: got A=%b B=%b want 10/10", fa, fb);
    end
    tick();
    drive(0, 1, 0, 1, 0, 0, 0);
    checks++;
    if (fa !== 2'b00 || fb !== 2'b00) begin
      errors++;
      $display("FAIL r0_blocked: got A=%b B=%b want 00/00", fa, fb);
    end
    tick();
    checks++;
    if (ex_cnt !== 3 || mem_cnt !== 1) begin
      errors++;
      $display("FAIL priority_cnt: got ex=%0d mem=%0d want 3/1", ex_cnt, mem_cnt);
    end
  endtask

  task automatic test_mixed();
    drive(0, 1, 3, 1, 4, 3, 4);
    checks++;
    if (fa !== 2'b10 || fb !== 2'b01) begin
      errors++;
      $display("FAIL mixed: got A=%b B=%b want 10/01", fa, fb);
    end
    tick();
    checks++;
    if (ex_cnt !== 4 || mem_cnt !== 2) begin
      errors++;
      $display("FAIL mixed_cnt: got ex=%0d mem=%0d want 4/2", ex_cnt, mem_cnt);
    end
  endtask

  task automatic test_random();
    logic [1:0] ea, eb;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 29) == 0),
            $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3));
      ea = ref_sel(int'(rs));
      eb = ref_sel(int'(rt));
      checks++;
      if (fa !== ea || fb !== eb) begin
        errors++;
        $display("FAIL rand_sel[%0d]: got A=%b B=%b want %b/%b",
                 i, fa, fb, ea, eb);
      end
      tick();
      checks++;
      if (int'(ex_cnt) != m_ex || int'(mem_cnt) != m_mem) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: got ex=%0d mem=%0d want %0d/%0d",
                 i, ex_cnt, mem_cnt, m_ex, m_mem);
      end
    end
  endtask

  task automatic test_saturate();
    drive(0, 1, 7, 1, 9, 7, 9);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) tick();
    checks++;
    if (int'(ex_cnt) != CMAX || int'(mem_cnt) != CMAX) begin
      errors++;
      $display("FAIL saturate: got ex=%0d mem=%0d want %0d/%0d",
               ex_cnt, mem_cnt, CMAX, CMAX);
    end
    drive(1, 1, 7, 1, 9, 7, 9);
    tick();
    checks++;
    if (ex_cnt !== 0 || mem_cnt !== 0) begin
      errors++;
      $display("FAIL sat_reset: got ex=%0d mem=%0d want 0/0", ex_cnt, mem_cnt);
    end
    drive(0, 1, 7, 1, 9, 7, 9);
    tick();
    checks++;
    if (ex_cnt !== 1 || mem_cnt !== 1) begin
      errors++;
      $display("FAIL post_reset: got ex=%0d mem=%0d want 1/1", ex_cnt, mem_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; wr_ex = 1'b0; wr_mem = 1'b0;
    rd_ex = '0; rd_mem = '0; rs = '0; rt = '0;
    test_reset();
    test_ex_a();
    test_ex_b();
    test_mem_b();
    test_priority();
    test_mixed();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
